assert_sched: RTL and testbench

Synthesizable check scheduler for simulation and emulation benches. It sequences up to N per-signal comparisons (test vs. pattern): arming, a settle window, then live checking until an error budget is exhausted. Simultaneous failures are queued per checker and reported one at a time through a round-robin valid/ack port. The block sits between DUT/reference outputs and the bench's reporting logic, replacing free-running per-signal checkers with one controlled, countable source of failures.

---
 rtl/assert_sched_pkg.sv | 46 ++++
 rtl/assert_sched_rr_arb.sv | 73 +++++++
 rtl/assert_sched.sv | 219 +++++++++++++++++++++
 tb/tb_assert_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/assert_sched_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : assert_sched_pkg
// Description : Shared types and helpers for the assert_sched check scheduler.
//               Holds the session state encoding, the widths that derive from
//               the counter / lane limits, and a width-aware saturating adder.
// Revision    : 1.0 - initial release
// ============================================================================
package assert_sched_pkg;

    // Session state of the scheduler.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    // Settle window is at most 255 cycles, so an 8-bit down-counter suffices.
    localparam int c_settle_w  = 8;
    // Widest counter and lane count the block supports.
    localparam int c_max_cnt_w = 32;
    localparam int c_max_chk   = 32;

    // Add two values and clamp the result to the all-ones value of a counter
    // that is only w bits wide. Operands are carried at the maximum width so
    // one helper serves every CNT_W.
    function automatic logic [c_max_cnt_w-1:0] sat_add(
        input logic [c_max_cnt_w-1:0] a,
        input logic [c_max_cnt_w-1:0] b,
        input int unsigned            w
    );
        logic [c_max_cnt_w:0] sum;
        logic [c_max_cnt_w:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        if (w >= c_max_cnt_w) begin
            lim = {1'b0, {c_max_cnt_w{1'b1}}};
        end else begin
            lim = ((c_max_cnt_w+1)'(1) << w) - (c_max_cnt_w+1)'(1);
        end
        return (sum > lim) ? lim[c_max_cnt_w-1:0] : sum[c_max_cnt_w-1:0];
    endfunction

endpackage : assert_sched_pkg
`default_nettype wire

// File: rtl/assert_sched_rr_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rr_arb
// Description : N-input round-robin selector. Picks the first requesting
//               input strictly after the last advanced-on index, wrapping.
//               The pointer moves only when the consumer advances, so the
//               selection is a pure function of req and the pointer.
// Revision    : 1.0 - initial release
// Ports       :
//   clk       in  1          clock
//   rst_n     in  1          asynchronous active-low reset
//   clr       in  1          return pointer so that index 0 is next
//   req       in  N          request vector
//   advance   in  1          the presented grant was consumed
//   adv_id    in  ID_W       index that was consumed
//   gnt_valid out 1          at least one request is present
//   gnt_id    out ID_W       selected index
// ============================================================================
module rr_arb #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    input  logic [$clog2(N)-1:0] adv_id,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int c_id_w = $clog2(N);
    // Pointer holds the last consumed index; N-1 makes lane 0 come first.
    localparam logic [c_id_w-1:0] c_ptr_init = c_id_w'(N-1);

    logic [c_id_w-1:0] r_last;
    logic [c_id_w-1:0] w_gnt_id;
    logic [c_id_w-1:0] w_sel;
    logic              w_found;
    int                w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= c_ptr_init;
        end else if (clr) begin
            r_last <= c_ptr_init;
        end else if (advance) begin
            r_last <= adv_id;
        end
    end

    // Walk the N positions after the pointer; the first hit wins.
    always_comb begin
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        w_sel    = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(r_last) + k) % N;
            w_sel = c_id_w'(w_idx);
            if (!w_found && req[w_sel]) begin
                w_found  = 1'b1;
                w_gnt_id = w_sel;
            end
        end
    end

    assign gnt_valid = |req;
    assign gnt_id    = w_gnt_id;

endmodule : rr_arb
`default_nettype wire

// File: rtl/assert_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : assert_sched
// Description : Check scheduler. Arms a session, waits a settle window, then
//               compares test against pat on every enabled lane until the
//               error budget is spent. Each lane keeps one pending failure
//               with the session cycle of its first mismatch; pending
//               failures are reported one at a time, round-robin, over a
//               valid/ack port.
// Revision    : 1.0 - initial release
// Ports       :
//   clk        in  1       clock
//   rst_n      in  1       asynchronous active-low reset
//   arm        in  1       start a session (ignored outside IDLE)
//   disarm     in  1       end the session, drop pending reports
//   chk_en     in  N_CHK   per-lane compare enable
//   test       in  N_CHK   observed value per lane
//   pat        in  N_CHK   expected value per lane
//   fail_ack   in  1       consumer takes the presented report
//   fail_valid out 1       a report is presented
//   fail_id    out ID_W    lane of the presented report
//   fail_cyc   out CNT_W   session cycle of that lane's first mismatch
//   err_count  out CNT_W   saturating mismatch total of the session
//   active     out 1       comparisons are live (CHECK)
//   stop       out 1       error budget exhausted (HALT)
// ============================================================================
module assert_sched
    import assert_sched_pkg::*;
#(
    parameter int N_CHK   = 4,
    parameter int CNT_W   = 16,
    parameter int SETTLE  = 2,
    parameter int MAX_ERR = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic [N_CHK-1:0]         chk_en,
    input  logic [N_CHK-1:0]         test,
    input  logic [N_CHK-1:0]         pat,
    input  logic                     fail_ack,
    output logic                     fail_valid,
    output logic [$clog2(N_CHK)-1:0] fail_id,
    output logic [CNT_W-1:0]         fail_cyc,
    output logic [CNT_W-1:0]         err_count,
    output logic                     active,
    output logic                     stop
);

    localparam int c_id_w = $clog2(N_CHK);
    localparam logic [CNT_W-1:0]      c_max_err     = CNT_W'(MAX_ERR);
    localparam logic [c_settle_w-1:0] c_settle_init = (SETTLE > 0) ? c_settle_w'(SETTLE - 1) : '0;

    state_t                  r_state;
    logic [c_settle_w-1:0]   r_settle;
    logic [CNT_W-1:0]        r_cyc;
    logic [CNT_W-1:0]        r_err;
    logic                    r_active;
    logic                    r_stop;
    logic [N_CHK-1:0]        r_pend;
    logic [CNT_W-1:0]        r_cap [N_CHK];
    logic                    r_lock;
    logic [c_id_w-1:0]       r_lock_id;

    logic                    w_arm_go;
    logic                    w_disarm;
    logic                    w_sample;
    logic [N_CHK-1:0]        w_mis;
    logic [c_max_cnt_w-1:0]  w_pop;
    logic [CNT_W-1:0]        w_err_next;
    logic                    w_halt;
    logic                    w_gnt_valid;
    logic [c_id_w-1:0]       w_gnt_id;
    logic [c_id_w-1:0]       w_fail_id;
    logic                    w_ack;
    logic [N_CHK-1:0]        w_clr;

    // disarm beats arm; arm is only honoured from IDLE.
    assign w_arm_go = arm & ~disarm & (r_state == ST_IDLE);
    assign w_disarm = disarm & (r_state != ST_IDLE);

    // A disarm cycle closes the session, so its compares are not counted.
    assign w_sample = (r_state == ST_CHECK) & ~disarm;
    assign w_mis    = w_sample ? (chk_en & (test ^ pat)) : '0;

    assign w_pop      = c_max_cnt_w'($countones(w_mis));
    assign w_err_next = CNT_W'(sat_add(c_max_cnt_w'(r_err), w_pop, CNT_W));
    assign w_halt     = (w_err_next >= c_max_err);

    // ------------------------------------------------------------------
    // Session FSM, counters and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_cyc    <= '0;
            r_err    <= '0;
            r_active <= 1'b0;
            r_stop   <= 1'b0;
        end else if (w_disarm) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arm_go) begin
                        r_err    <= '0;
                        r_cyc    <= '0;
                        r_settle <= c_settle_init;
                        if (SETTLE > 0) begin
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state  <= ST_CHECK;
                            r_active <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state  <= ST_CHECK;
                        r_active <= 1'b1;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_err <= w_err_next;
                    if (r_cyc != '1) begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                    if (w_halt) begin
                        r_state  <= ST_HALT;
                        r_active <= 1'b0;
                        r_stop   <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // Counters frozen; reports keep draining.
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                    r_stop   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Report selection
    // ------------------------------------------------------------------
    rr_arb #(
        .N (N_CHK)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_arm_go),
        .req       (r_pend),
        .advance   (w_ack),
        .adv_id    (w_fail_id),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    // Once a report has been shown without an ack it is locked, so a newly
    // pending lane that sorts earlier in round-robin order cannot displace it.
    assign w_fail_id = r_lock ? r_lock_id : w_gnt_id;
    assign w_ack     = w_gnt_valid & fail_ack;

    always_comb begin
        w_clr            = '0;
        w_clr[w_fail_id] = w_ack;
    end

    // ------------------------------------------------------------------
    // Per-lane pending bits and first-mismatch capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            for (int i = 0; i < N_CHK; i++) begin
                r_cap[i] <= '0;
            end
        end else if (w_arm_go || w_disarm) begin
            r_pend    <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else begin
            // A mismatch in the lane's own ack cycle re-arms it (set wins).
            r_pend <= (r_pend & ~w_clr) | w_mis;
            for (int i = 0; i < N_CHK; i++) begin
                if (w_mis[i] && (!r_pend[i] || w_clr[i])) begin
                    r_cap[i] <= r_cyc;
                end
            end
            if (w_ack) begin
                r_lock <= 1'b0;
            end else if (w_gnt_valid) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_fail_id;
            end
        end
    end

    assign fail_valid = w_gnt_valid;
    assign fail_id    = w_gnt_valid ? w_fail_id : '0;
    assign fail_cyc   = w_gnt_valid ? r_cap[w_fail_id] : '0;
    assign err_count  = r_err;
    assign active     = r_active;
    assign stop       = r_stop;

endmodule : assert_sched
`default_nettype wire

// File: tb/tb_assert_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_assert_sched
// Description : Scoreboard bench for assert_sched. Expected reports are
//               queued when mismatches are driven; a monitor pops and
//               compares each report as it is acknowledged. A second
//               instance with a 4-bit counter exercises saturation and a
//               zero settle window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assert_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: SETTLE=2, MAX_ERR=8
    logic        m_arm = 1'b0, m_disarm = 1'b0, m_ack = 1'b0;
    logic [3:0]  m_en = 4'h0, m_tst = 4'h0;
    logic [3:0]  m_pat = 4'hA;
    logic        m_valid, m_active, m_stop;
    logic [1:0]  m_id;
    logic [15:0] m_cyc, m_err;

    assert_sched #(.N_CHK(4), .CNT_W(16), .SETTLE(2), .MAX_ERR(8)) u_main (
        .clk(clk), .rst_n(rst_n), .arm(m_arm), .disarm(m_disarm),
        .chk_en(m_en), .test(m_tst), .pat(m_pat), .fail_ack(m_ack),
        .fail_valid(m_valid), .fail_id(m_id), .fail_cyc(m_cyc),
        .err_count(m_err), .active(m_active), .stop(m_stop)
    );

    // Saturation instance: CNT_W=4, SETTLE=0, MAX_ERR=15
    logic        s_arm = 1'b0, s_disarm = 1'b0, s_ack = 1'b0;
    logic [3:0]  s_en = 4'h0, s_tst = 4'h0;
    logic [3:0]  s_pat = 4'h0;
    logic        s_valid, s_active, s_stop;
    logic [1:0]  s_id;
    logic [3:0]  s_cyc, s_err;

    assert_sched #(.N_CHK(4), .CNT_W(4), .SETTLE(0), .MAX_ERR(15)) u_sat (
        .clk(clk), .rst_n(rst_n), .arm(s_arm), .disarm(s_disarm),
        .chk_en(s_en), .test(s_tst), .pat(s_pat), .fail_ack(s_ack),
        .fail_valid(s_valid), .fail_id(s_id), .fail_cyc(s_cyc),
        .err_count(s_err), .active(s_active), .stop(s_stop)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] cyc;
    } rpt_t;
    rpt_t exp_q[$];

    task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] cyc);
        exp_q.push_back('{id: id, cyc: cyc});
    endtask

    // Enable lanes 'en'; lanes in 'mis' get a test value differing from pat.
    task automatic set_m(input logic [3:0] en, input logic [3:0] mis);
        m_en  = en;
        m_tst = m_pat ^ mis;
    endtask

    // Monitor: every acknowledged report must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ack) begin
            rpt_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL report_unexpected: got id %0d cyc %0d, expected no report", m_id, m_cyc);
            end else begin
                e = exp_q.pop_front();
                do_check("report_id",  32'(m_id),  32'(e.id));
                do_check("report_cyc", 32'(m_cyc), 32'(e.cyc));
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Reset state
        do_check("rst_valid",  32'(m_valid),  32'(0));
        do_check("rst_id",     32'(m_id),     32'(0));
        do_check("rst_cyc",    32'(m_cyc),    32'(0));
        do_check("rst_err",    32'(m_err),    32'(0));
        do_check("rst_active", 32'(m_active), 32'(0));
        do_check("rst_stop",   32'(m_stop),   32'(0));

        // Mismatches while IDLE are not sampled
        set_m(4'hF, 4'hF);
        tick(); tick();
        do_check("idle_err",   32'(m_err),   32'(0));
        do_check("idle_valid", 32'(m_valid), 32'(0));

        // Arm; lane 1 mismatches during settle (ignored)
        m_arm = 1'b1; tick();
        m_arm = 1'b0; set_m(4'hF, 4'h2); tick();
        tick();                                  // first CHECK cycle, cyc 0
        do_check("settle_err",   32'(m_err),    32'(0));
        do_check("settle_valid", 32'(m_valid),  32'(0));
        do_check("check_active", 32'(m_active), 32'(1));
        set_m(4'hB, 4'h4);                       // lane 2 differs but disabled
        tick();                                  // cyc 1
        do_check("gated_err", 32'(m_err), 32'(0));
        set_m(4'hF, 4'h0); tick(); tick();       // cyc 3
        set_m(4'hF, 4'h2); push(2'd1, 16'd3); tick();
        set_m(4'hF, 4'h0);
        do_check("l1_err",    32'(m_err),    32'(1));
        do_check("l1_valid",  32'(m_valid),  32'(1));
        do_check("l1_id",     32'(m_id),     32'(1));
        do_check("l1_cyc",    32'(m_cyc),    32'(3));
        do_check("l1_active", 32'(m_active), 32'(1));
        do_check("l1_stop",   32'(m_stop),   32'(0));
        m_ack = 1'b1; tick(); m_ack = 1'b0;      // cyc 5
        do_check("l1_acked_valid", 32'(m_valid), 32'(0));

        // Lanes 0,2,3 together, ack held: round-robin after lane 1 -> 2,3,0
        set_m(4'hF, 4'hD);
        push(2'd2, 16'd5); push(2'd3, 16'd5); push(2'd0, 16'd5);
        m_ack = 1'b1; tick();
        set_m(4'hF, 4'h0);
        do_check("multi_err",    32'(m_err),    32'(4));
        do_check("multi_active", 32'(m_active), 32'(1));
        tick(); tick(); tick();
        m_ack = 1'b0;
        do_check("multi_drained", 32'(m_valid), 32'(0));

        // Two pending, then disarm
        set_m(4'hF, 4'h3); tick();
        set_m(4'hF, 4'h0);
        do_check("pend2_err",   32'(m_err),   32'(6));
        do_check("pend2_valid", 32'(m_valid), 32'(1));
        do_check("pend2_id",    32'(m_id),    32'(1));
        m_disarm = 1'b1; tick(); m_disarm = 1'b0;
        do_check("disarm_valid",  32'(m_valid),  32'(0));
        do_check("disarm_err",    32'(m_err),    32'(6));
        do_check("disarm_active", 32'(m_active), 32'(0));

        // arm + disarm together from IDLE: arm ignored, err not cleared
        m_arm = 1'b1; m_disarm = 1'b1; tick();
        m_arm = 1'b0; m_disarm = 1'b0; tick();
        do_check("armdis_err",    32'(m_err),    32'(6));
        do_check("armdis_active", 32'(m_active), 32'(0));

        // Fresh session: lane 2 mismatches 5 cycles, one report
        m_arm = 1'b1; tick();
        m_arm = 1'b0; tick(); tick();            // CHECK, cyc 0
        do_check("rearm_err",    32'(m_err),    32'(0));
        do_check("rearm_active", 32'(m_active), 32'(1));
        set_m(4'hF, 4'h4); push(2'd2, 16'd0);
        repeat (5) tick();                       // cyc 5
        set_m(4'hF, 4'h0);
        do_check("rep_err",   32'(m_err),   32'(5));
        do_check("rep_valid", 32'(m_valid), 32'(1));
        do_check("rep_id",    32'(m_id),    32'(2));
        do_check("rep_cyc",   32'(m_cyc),   32'(0));
        m_ack = 1'b1; tick(); m_ack = 1'b0;      // cyc 6
        do_check("rep_single", 32'(m_valid), 32'(0));

        // Budget: 5 + 4 = 9 >= 8 -> HALT
        set_m(4'hF, 4'hF); tick();
        do_check("halt_err",    32'(m_err),    32'(9));
        do_check("halt_stop",   32'(m_stop),   32'(1));
        do_check("halt_active", 32'(m_active), 32'(0));
        tick();
        do_check("halt_frozen", 32'(m_err), 32'(9));
        set_m(4'hF, 4'h0);
        push(2'd3, 16'd6); push(2'd0, 16'd6); push(2'd1, 16'd6); push(2'd2, 16'd6);
        m_ack = 1'b1; repeat (4) tick(); m_ack = 1'b0;
        do_check("halt_drained", 32'(m_valid), 32'(0));
        do_check("halt_hold",    32'(m_stop),  32'(1));
        m_disarm = 1'b1; tick(); m_disarm = 1'b0;
        do_check("halt_disarm_stop", 32'(m_stop), 32'(0));
        do_check("queue_empty", 32'(exp_q.size()), 32'(0));

        // Saturation instance: SETTLE=0, 4 lanes x 5 cycles, 4-bit counter
        s_arm = 1'b1; tick(); s_arm = 1'b0;
        do_check("sat_active0", 32'(s_active), 32'(1));
        do_check("sat_err0",    32'(s_err),    32'(0));
        s_en = 4'hF; s_tst = 4'hF;
        repeat (5) tick();
        s_en = 4'h0; s_tst = 4'h0;
        do_check("sat_err",    32'(s_err),    32'(15));
        do_check("sat_stop",   32'(s_stop),   32'(1));
        do_check("sat_active", 32'(s_active), 32'(0));
        do_check("sat_valid",  32'(s_valid),  32'(1));
        do_check("sat_id",     32'(s_id),     32'(0));
        do_check("sat_cyc",    32'(s_cyc),    32'(0));

        // Asynchronous reset mid-session
        rst_n = 1'b0; #1;
        do_check("arst_valid", 32'(s_valid), 32'(0));
        do_check("arst_err",   32'(s_err),   32'(0));
        do_check("arst_stop",  32'(s_stop),  32'(0));
        do_check("arst_merr",  32'(m_err),   32'(0));
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_assert_sched
`default_nettype wire
